// File: rtl/clock_pkg.sv
// clock_pkg: shared state encoding and timing defaults for the clock time-setting logic
package clock_pkg;
   typedef enum logic [1:0] {ST_NORMAL = 2'd0, ST_SET_HOUR = 2'd1, ST_SET_MIN = 2'd2} state_t;
   localparam int TIMEOUT_MS_DEF = 10000;
   localparam int BLINK_MS_DEF = 250;
endpackage

// File: rtl/ms_tick_cnt.sv
// ms_tick_cnt: counts TICK pulses up to LIMIT, either saturating or auto-reloading
// Ports: CLK clock, RST_N async active-low reset, CLR sync clear (wins over TICK),
//        TICK count enable, DONE one-cycle pulse on the tick that reaches LIMIT
module ms_tick_cnt #(
   parameter int LIMIT = 10,
   parameter bit SATURATE = 1'b1
) (
   input  logic CLK,
   input  logic RST_N,
   input  logic CLR,
   input  logic TICK,
   output logic DONE
);
   localparam int W = $clog2(LIMIT + 1);
   localparam logic [W-1:0] TOP = W'(LIMIT);
   localparam logic [W-1:0] PRE = W'(LIMIT - 1);
   logic [W-1:0] cnt;
   // DONE is combinational so the consumer reacts on the very tick that reaches LIMIT
   assign DONE = TICK & ~CLR & (cnt == PRE);
   always_ff @(posedge CLK or negedge RST_N)
      if (!RST_N) cnt <= '0;
      else if (CLR) cnt <= '0;
      else if (TICK) cnt <= (cnt == PRE) ? (SATURATE ? TOP : '0) : (cnt == TOP) ? TOP : cnt + 1'b1;
endmodule

// File: rtl/setup_ctrl.sv
// setup_ctrl: time-setting FSM for the 24-hour clock (NORMAL -> SET_HOUR -> SET_MIN -> NORMAL)
// Ports: CLK, RST_N (async active-low); ENABLE_kHz 1 ms tick; MODE_PLS/UP_PLS debounced
//        button pulses; RUN counting enable; INC_HOUR/INC_MIN/CLR_SEC one-cycle strobes;
//        SEL current state; BLANK_HOUR/BLANK_MIN blink blanking for the edited field.
// Build option: SETUP_CTRL_BLINK_EN enables the blink logic; otherwise both blanks are 0.
module setup_ctrl
   import clock_pkg::*;
#(
   parameter int TIMEOUT_MS = TIMEOUT_MS_DEF,
   parameter int BLINK_MS = BLINK_MS_DEF
) (
   input  logic       CLK,
   input  logic       RST_N,
   input  logic       ENABLE_kHz,
   input  logic       MODE_PLS,
   input  logic       UP_PLS,
   output logic       RUN,
   output logic       INC_HOUR,
   output logic       INC_MIN,
   output logic       CLR_SEC,
   output logic [1:0] SEL,
   output logic       BLANK_HOUR,
   output logic       BLANK_MIN
);
   if (TIMEOUT_MS < 1 || BLINK_MS < 1) $error("setup_ctrl: TIMEOUT_MS and BLINK_MS must be >= 1");
   state_t state, nxt;
   logic clr, to_done, inc_h, inc_m, clr_s;
   // Any button activity or being in NORMAL restarts both idle and blink timing
   assign clr = MODE_PLS | UP_PLS | (state == ST_NORMAL);
   ms_tick_cnt #(.LIMIT(TIMEOUT_MS), .SATURATE(1'b1)) u_timeout (
      .CLK(CLK), .RST_N(RST_N), .CLR(clr), .TICK(ENABLE_kHz), .DONE(to_done));
   always_comb begin
      nxt = state;
      if (MODE_PLS) nxt = (state == ST_NORMAL) ? ST_SET_HOUR : (state == ST_SET_HOUR) ? ST_SET_MIN : ST_NORMAL;
      else if (to_done) nxt = ST_NORMAL;
      inc_h = UP_PLS & ~MODE_PLS & (state == ST_SET_HOUR);
      inc_m = UP_PLS & ~MODE_PLS & (state == ST_SET_MIN);
      clr_s = (MODE_PLS & (state == ST_SET_MIN)) | to_done;
   end
   always_ff @(posedge CLK or negedge RST_N)
      if (!RST_N) begin
         state <= ST_NORMAL;
         RUN <= 1'b1;
         INC_HOUR <= 1'b0;
         INC_MIN <= 1'b0;
         CLR_SEC <= 1'b0;
      end else begin
         state <= nxt;
         RUN <= nxt == ST_NORMAL;
         INC_HOUR <= inc_h;
         INC_MIN <= inc_m;
         CLR_SEC <= clr_s;
      end
   assign SEL = state;
`ifdef SETUP_CTRL_BLINK_EN
   logic bl_done, off, off_nxt;
   ms_tick_cnt #(.LIMIT(BLINK_MS), .SATURATE(1'b0)) u_blink (
      .CLK(CLK), .RST_N(RST_N), .CLR(clr), .TICK(ENABLE_kHz), .DONE(bl_done));
   // Entry, UP and NORMAL force the visible phase so a fresh value shows at once
   assign off_nxt = ~clr & (nxt != ST_NORMAL) & (off ^ bl_done);
   always_ff @(posedge CLK or negedge RST_N)
      if (!RST_N) begin
         off <= 1'b0;
         BLANK_HOUR <= 1'b0;
         BLANK_MIN <= 1'b0;
      end else begin
         off <= off_nxt;
         BLANK_HOUR <= off_nxt & (nxt == ST_SET_HOUR);
         BLANK_MIN <= off_nxt & (nxt == ST_SET_MIN);
      end
`else
   assign BLANK_HOUR = 1'b0;
   assign BLANK_MIN = 1'b0;
`endif
endmodule
